// File: rtl/traffic_pkg.sv
// Shared types and cycle codes for the traffic-light phase sequencer.
// Cycle codes match what the semaphore decoder expects on ciclo.
package traffic_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_ALT    = 2'd2,
    MODE_ALLRED = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_EXIT    = 2'd1,
    ST_SPECIAL = 2'd2,
    ST_ENTER   = 2'd3
  } state_e;

  localparam logic [4:0] CODE_G0    = 5'b00000;
  localparam logic [4:0] CODE_Y0    = 5'b00001;
  localparam logic [4:0] CODE_G1    = 5'b00010;
  localparam logic [4:0] CODE_Y1    = 5'b00011;
  localparam logic [4:0] CODE_G2    = 5'b00100;
  localparam logic [4:0] CODE_Y2    = 5'b00101;
  localparam logic [4:0] CODE_G3    = 5'b00110;
  localparam logic [4:0] CODE_CLR   = 5'b00111;
  localparam logic [4:0] CODE_FLASH = 5'b01000;
  localparam logic [4:0] CODE_ALT   = 5'b01001;

  function automatic logic [4:0] special_code(input mode_e m);
    case (m)
      MODE_FLASH: special_code = CODE_FLASH;
      MODE_ALT:   special_code = CODE_ALT;
      default:    special_code = CODE_CLR;
    endcase
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Phase timer: counts one-second ticks from zero, cleared on every phase change.
// expire is combinational and fires on the tick that completes `limit` ticks.
module tick_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic       expire
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= count + 8'd1;
    end
  end

  assign expire = tick && (count == (limit - 8'd1));

endmodule

// File: rtl/phase_sequencer.sv
// Steps four approaches through green/yellow/all-red on the 1 Hz tick and
// sequences entry to and exit from flashing, alternating and all-red modes.
module phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_S  = 20,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 2,
  parameter int BLINK_S  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic [4:0] ciclo,
  output logic       dest,
  output logic       phase_strobe
);

  localparam logic [7:0] LIM_G   = 8'(GREEN_S);
  localparam logic [7:0] LIM_Y   = 8'(YELLOW_S);
  localparam logic [7:0] LIM_R   = 8'(ALLRED_S);
  localparam logic [7:0] BLINK_T = 8'(GREEN_S - BLINK_S);

  state_e     state, state_n;
  logic [2:0] phase, phase_n;   // NORMAL phase index; equals its cycle code
  logic       change;
  logic       tmr_clr;
  logic [7:0] limit;
  logic [7:0] count;
  logic [7:0] cnt_nxt;
  logic       expire;
  mode_e      md;
  logic [4:0] code_n;
  logic       dest_n;

  assign md = mode_e'(mode);

  always_comb begin
    limit = LIM_R;
    case (state)
      ST_RUN: begin
        if (phase == 3'd7)   limit = LIM_R;
        else if (phase[0])   limit = LIM_Y;
        else                 limit = LIM_G;
      end
      ST_EXIT: limit = LIM_Y;
      default: limit = LIM_R;
    endcase
  end

  tick_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .tick   (tick),
    .limit  (limit),
    .count  (count),
    .expire (expire)
  );

  always_comb begin
    state_n = state;
    phase_n = phase;
    change  = 1'b0;
    case (state)
      ST_RUN: begin
        // Expiry wins over a mode request; the mode is then judged
        // against the phase that follows.
        if (expire) begin
          change = 1'b1;
          if (phase[0] && (md != MODE_NORMAL)) state_n = ST_SPECIAL;
          else                                 phase_n = 3'(phase + 3'd1);
        end else if (!phase[0] && (md != MODE_NORMAL)) begin
          change  = 1'b1;
          state_n = ST_EXIT;
        end
      end
      ST_EXIT: begin
        if (expire) begin
          change  = 1'b1;
          state_n = (md == MODE_NORMAL) ? ST_ENTER : ST_SPECIAL;
        end
      end
      ST_SPECIAL: begin
        if (md == MODE_NORMAL) begin
          change  = 1'b1;
          state_n = ST_ENTER;
        end
      end
      default: begin
        if (md != MODE_NORMAL) begin
          change  = 1'b1;
          state_n = ST_SPECIAL;
        end else if (expire) begin
          change  = 1'b1;
          state_n = ST_RUN;
          phase_n = 3'd0;
        end
      end
    endcase
  end

  // SPECIAL has no duration, so its timer is held at zero.
  assign tmr_clr = change || (state_n == ST_SPECIAL);
  assign cnt_nxt = tmr_clr ? 8'd0 : (count + {7'd0, tick});

  always_comb begin
    code_n = CODE_CLR;
    dest_n = 1'b0;
    case (state_n)
      ST_RUN: begin
        code_n = {2'b00, phase_n};
        dest_n = !phase_n[0] && (cnt_nxt >= BLINK_T);
      end
      ST_EXIT:    code_n = {2'b00, 3'(phase_n + 3'd1)};
      ST_SPECIAL: begin
        code_n = special_code(md);
        dest_n = (md == MODE_FLASH) || (md == MODE_ALT);
      end
      default:    code_n = CODE_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ENTER;
      phase        <= 3'd0;
      ciclo        <= CODE_CLR;
      dest         <= 1'b0;
      phase_strobe <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      ciclo        <= code_n;
      dest         <= dest_n;
      phase_strobe <= (code_n != ciclo);
    end
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Traffic-light phase sequencer that generates the 5-bit cycle code and blink-enable consumed by the semaphore decoder, replacing the ESP32 as the source of `ciclo_esp32`/`dest_esp32`. It steps four approaches through green, yellow and all-red clearance on a one-second tick, and handles transitions into and out of the special modes: flashing yellow, alternating yellow/red and steady all-red. Sits between the 1 Hz tick source and the decoder in `top`.

## Interface
Parameters:
- `GREEN_S`, 20: green duration in ticks, range 2..255.
- `YELLOW_S`, 3: yellow/exit-clearance duration in ticks, range 1..255.
- `ALLRED_S`, 2: all-red clearance duration in ticks, range 1..255.
- `BLINK_S`, 3: trailing ticks of green with blink enabled; must satisfy 0 ≤ BLINK_S < GREEN_S.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle strobe, once per second.
- `mode` input 2: requested mode, a level signal: 0 NORMAL, 1 FLASH, 2 ALT, 3 ALLRED.
- `ciclo` output 5: cycle code to the decoder.
- `dest` output 1: blink enable to the decoder; ANDed with the 1 Hz pulse in `top`.
- `phase_strobe` output 1: one-cycle pulse whenever `ciclo` changes.

## Operation
- NORMAL phase order and codes: G0 00000, Y0 00001, G1 00010, Y1 00011, G2 00100, Y2 00101, G3 00110, CLR 00111 (all red, also acts as G3's clearance). After CLR the order wraps to G0.
- Phase durations: G* = GREEN_S, Y* = YELLOW_S, CLR = ALLRED_S.
- Special codes: FLASH 01000 with `dest`=1; ALT 01001 with `dest`=1; ALLRED 00111 with `dest`=0.
- States:
  - RUN: cycles through the NORMAL phases.
  - EXIT: clearance when leaving NORMAL.
  - SPECIAL: holds a fixed special code.
  - ENTER: all-red clearance before returning to NORMAL.
- Transitions:
  - RUN, mode≠NORMAL, current phase Gk: go to EXIT, code = Yk (for G3, code = 00111). Duration YELLOW_S.
  - RUN, mode≠NORMAL, current phase Yk or CLR: the current phase finishes its remaining time, then go to SPECIAL.
  - EXIT expires: go to SPECIAL, using the `mode` value sampled at expiry.
  - SPECIAL, mode changes to another special mode: new code on the next cycle.
  - SPECIAL, mode→NORMAL: go to ENTER, code 00111, duration ALLRED_S, then RUN at G0.
  - ENTER, mode≠NORMAL: go to SPECIAL immediately.
- Timer:
  - Counts `tick` strobes from 0.
  - Cleared on every code change.
  - A phase of N ticks expires on the cycle its Nth tick is seen.
  - Width is 8 bits; never wraps, because it is cleared at expiry.
- `dest` in G phases: 1 when count ≥ GREEN_S−BLINK_S, i.e. during the last BLINK_S ticks. 0 in Y phases, CLR, EXIT and ENTER.
- Simultaneous tick-expiry and mode change in the same cycle: the mode rule is evaluated against the post-expiry phase, and the tick is consumed by the expiry.
  - Example: G0 expiring while mode→FLASH goes to Y0 as a normal phase, then SPECIAL after Y0 completes.
- `mode` values are already synchronous; no metastability handling inside this block.

## Timing
- Reset values: state ENTER, `ciclo`=00111, `dest`=0, `phase_strobe`=0, count=0.
- All outputs are registered. `ciclo` and `dest` update on the cycle after the deciding `tick` or `mode` edge (latency 1).
- `phase_strobe` is asserted in the same cycle the new `ciclo` first appears.
- Reset asserted mid-phase: the next cycle shows the reset values regardless of `tick`.
- A `tick` held high for multiple cycles counts once per cycle. The source is required to be single-cycle.

## Structure
- `traffic_pkg` contains:
  - `mode_e` enum (2 bits).
  - `state_e` enum.
  - Code localparams: `CODE_G0`..`CODE_CLR`, `CODE_FLASH`=5'b01000, `CODE_ALT`=5'b01001.
- Sub-module `tick_timer`:
  - Ports: clk, rst, clr, tick, 8-bit `limit`.
  - Outputs: `count`, `expire` (combinational: tick && count==limit−1).
- The sequencer FSM plus output registers live in `phase_sequencer`.

## Test plan
- Test parameters for all scenarios: GREEN_S=4, YELLOW_S=2, ALLRED_S=1, BLINK_S=2, `tick` every 10 cycles.
- Reset release with mode=NORMAL:
  - Required sequence: 00111(1 tick), 00000(4), 00001(2), 00010(4), …, 00110(4), 00111(1), then wrap to 00000.
  - `phase_strobe` pulses once per change.
- `dest` in G1: 0 for ticks 1–2, 1 after the 2nd tick until the code becomes 00011; 0 throughout every Y phase.
- mode→FLASH during G2 at count 1: next cycle `ciclo`=00101; after 2 ticks `ciclo`=01000, `dest`=1.
- SPECIAL FLASH → ALT: next cycle 01001. Then mode→NORMAL: 00111 for 1 tick, then 00000.
- Tick expiry of G0 coincident with mode→ALLRED: 00001 runs a full 2 ticks, then 00111 held with `dest`=0.
- `rst` pulsed for one cycle during Y1: next cycle `ciclo`=00111, `dest`=0; the sequence restarts as in the first scenario.
